// File: rtl/load_unit.sv
// Multi-cycle RV32I load unit: word-aligned reads with a ready handshake, split
// accesses across word boundaries, byte/half extraction with sign or zero extension.
module load_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        funct3_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       data_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic [31:0]       mem_data_i
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD0  = 3'd1;
    localparam logic [2:0] S_RD1  = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [31:0]       lo_q;
    logic [ADDR_W-1:0] word_addr;
    logic [1:0]        off;

    function automatic logic is_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Only legal types reach this point, so f3[1:0]==2'b10 means LW.
    function automatic logic is_split(input logic [2:0] f3, input logic [1:0] o);
        return ((f3[1:0] == 2'b01) && (o == 2'b11)) ||
               ((f3[1:0] == 2'b10) && (o != 2'b00));
    endfunction

    function automatic logic [31:0] extract(input logic [63:0] dw,
                                            input logic [1:0]  o,
                                            input logic [2:0]  f3);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = 32'(dw >> {o, 3'b000});
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            F3_LB:   extract = 32'(b);
            F3_LH:   extract = 32'(h);
            F3_LBU:  extract = {24'd0, sh[7:0]};
            F3_LHU:  extract = {16'd0, sh[15:0]};
            default: extract = sh;
        endcase
    endfunction

    assign off       = addr_q[1:0];
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            addr_q <= '0;
            f3_q   <= '0;
            lo_q   <= '0;
            data_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_i) begin
                        addr_q <= addr_i;
                        f3_q   <= funct3_i;
                        if (is_illegal(funct3_i)) begin
                            data_o <= '0;
                            state  <= S_ERR;
                        end else begin
                            state  <= S_RD0;
                        end
                    end
                end
                S_RD0: begin
                    if (mem_ready_i) begin
                        lo_q <= mem_data_i;
                        if (is_split(f3_q, off)) begin
                            state <= S_RD1;
                        end else begin
                            data_o <= extract({32'd0, mem_data_i}, off, f3_q);
                            state  <= S_FIN;
                        end
                    end
                end
                // Second word arrives directly from memory; first word comes from lo_q.
                S_RD1: begin
                    if (mem_ready_i) begin
                        data_o <= extract({mem_data_i, lo_q}, off, f3_q);
                        state  <= S_FIN;
                    end
                end
                S_FIN:   state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = (state != S_IDLE);
    assign done_o     = (state == S_FIN) || (state == S_ERR);
    assign err_o      = (state == S_ERR);
    assign mem_rd_o   = (state == S_RD0) || (state == S_RD1);
    assign mem_addr_o = (state == S_RD0) ? word_addr :
                        (state == S_RD1) ? word_addr + ADDR_W'(4) : '0;

endmodule
